// File: rtl/i2c_passthru_pkg.sv
// Shared encodings and defaults for the I2C pass-through bit transmitter.
package i2c_passthru_pkg;

   localparam int F_REF_T_LOW_DEF       = 38;
   localparam int WIDTH_F_REF_T_LOW_DEF = 6;

   typedef enum logic [3:0] {
      ST_IDLE         = 4'd0,
      ST_SCL0_SETUP   = 4'd1,
      ST_SCL0_RELEASE = 4'd2,
      ST_SCL1_INIT    = 4'd3,
      ST_SCL1_MID     = 4'd4,
      ST_SCL1_FIN     = 4'd5,
      ST_SCL0_END     = 4'd6,
      ST_VIOLATION    = 4'd7
   } state_t;

endpackage

// File: rtl/i2c_passthru_reftimer.sv
// Counts rising edges of a slow reference down to zero; a load request
// holds the count at its full value. Also used by the receive side.
module i2c_passthru_reftimer #(
   parameter int F_REF_T_LOW = 38,
   parameter int WIDTH       = 6
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_f_ref,
   input  logic i_load,
   output logic o_tc
);

   logic             r_f_ref_prev;
   logic [WIDTH-1:0] r_count;
   logic             w_edge;

   assign w_edge = i_f_ref & ~r_f_ref_prev;
   assign o_tc   = (r_count == '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_f_ref_prev <= 1'b0;
         r_count      <= WIDTH'(F_REF_T_LOW);
      end else begin
         r_f_ref_prev <= i_f_ref;
         if (i_load)
            r_count <= WIDTH'(F_REF_T_LOW);
         else if (w_edge && !o_tc)
            r_count <= r_count - WIDTH'(1);
      end
   end

endmodule

// File: rtl/i2c_passthru_bittx.sv
// Transmit side of an I2C pass-through: sequences SCL/SDA for one bit,
// mirrors the far side's mid-high SDA change, and flags SCL contention.
module i2c_passthru_bittx
   import i2c_passthru_pkg::*;
#(
   parameter int F_REF_T_LOW       = F_REF_T_LOW_DEF,
   parameter int WIDTH_F_REF_T_LOW = WIDTH_F_REF_T_LOW_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_f_ref,
   input  logic i_start_tx,
   input  logic i_tx_sda_init,
   input  logic i_tx_release_sda,
   input  logic i_rx_sda_mid_change,
   input  logic i_rx_sda_final,
   input  logic i_rx_done,
   input  logic i_scl,
   output logic o_scl,
   output logic o_sda,
   output logic o_tx_done,
   output logic o_violation
);

   state_t r_state;
   state_t w_state_nxt;
   logic   r_init, r_rel, r_sda_hold, r_sda_last;
   logic   w_latch, w_reload, w_load, w_tc;
   logic   w_drv_init, w_drv_inv;

   assign w_load     = w_reload || (r_state == ST_IDLE) || (r_state == ST_SCL0_RELEASE);
   assign w_drv_init = r_rel | r_init;
   assign w_drv_inv  = r_rel | ~r_init;

   i2c_passthru_reftimer #(
      .F_REF_T_LOW (F_REF_T_LOW),
      .WIDTH       (WIDTH_F_REF_T_LOW)
   ) u_reftimer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_f_ref (i_f_ref),
      .i_load  (w_load),
      .o_tc    (w_tc)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_init     <= 1'b1;
         r_rel      <= 1'b1;
         r_sda_hold <= 1'b1;
         r_sda_last <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_sda_last <= o_sda;
         if (w_latch) begin
            r_init <= i_tx_sda_init;
            r_rel  <= i_tx_release_sda;
         end
         if (r_state == ST_SCL0_END)
            r_sda_hold <= r_sda_last;
      end
   end

   // SCL dropping while we release it beats every other transition in the high phase.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_reload    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start_tx) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_SCL0_SETUP;
            end
         end
         ST_SCL0_SETUP:   if (w_tc) w_state_nxt = ST_SCL0_RELEASE;
         ST_SCL0_RELEASE: if (i_scl) w_state_nxt = ST_SCL1_INIT;
         ST_SCL1_INIT: begin
            if (!i_scl)
               w_state_nxt = ST_VIOLATION;
            else if (w_tc && i_rx_sda_mid_change) begin
               w_state_nxt = ST_SCL1_MID;
               w_reload    = 1'b1;
            end else if (w_tc && i_rx_done)
               w_state_nxt = ST_SCL0_END;
         end
         ST_SCL1_MID: begin
            if (!i_scl)
               w_state_nxt = ST_VIOLATION;
            else if (w_tc && i_rx_done) begin
               if (i_rx_sda_final == r_init) begin
                  w_state_nxt = ST_SCL1_FIN;
                  w_reload    = 1'b1;
               end else
                  w_state_nxt = ST_SCL0_END;
            end
         end
         ST_SCL1_FIN: begin
            if (!i_scl)
               w_state_nxt = ST_VIOLATION;
            else if (w_tc)
               w_state_nxt = ST_SCL0_END;
         end
         ST_SCL0_END:  w_state_nxt = ST_IDLE;
         ST_VIOLATION: w_state_nxt = ST_VIOLATION;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_scl       = 1'b0;
      o_sda       = 1'b1;
      o_tx_done   = 1'b0;
      o_violation = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_sda     = r_sda_hold;
            o_tx_done = 1'b1;
         end
         ST_SCL0_SETUP:   o_sda = w_drv_init;
         ST_SCL0_RELEASE,
         ST_SCL1_INIT,
         ST_SCL1_FIN: begin
            o_scl = 1'b1;
            o_sda = w_drv_init;
         end
         ST_SCL1_MID: begin
            o_scl = 1'b1;
            o_sda = w_drv_inv;
         end
         ST_SCL0_END:  o_sda = r_sda_last;
         ST_VIOLATION: begin
            o_scl       = 1'b1;
            o_violation = 1'b1;
         end
         default: o_sda = 1'b1;
      endcase
   end

endmodule

// File: doc/i2c_passthru_bittx.md
I2C_PASSTHRU_BITTX -- requirements
Module: i2c_passthru_bittx

Interface
REQ-001 Parameter F_REF_T_LOW, default 38: minimum i_f_ref rising edges for each timed phase (t_low, t_high, t_su_sta, t_hd_sta, t_su_sto). Legal values are 2 or more.
REQ-002 Parameter WIDTH_F_REF_T_LOW, default 6: timer width, equal to ceil(log2(F_REF_T_LOW+1)).
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port i_clk, input, 1: clock.
REQ-005 Port i_rst, input, 1: asynchronous active-high reset.
REQ-006 Port i_f_ref, input, 1: timing reference; only its rising edges count.
REQ-007 Port i_start_tx, input, 1: start one bit; sampled in ST_IDLE only.
REQ-008 Port i_tx_sda_init, input, 1: SDA value for the low phase and the start of the high phase.
REQ-009 Port i_tx_release_sda, input, 1: when 1, drive o_sda=1 for the whole bit (the far side owns SDA).
REQ-010 Port i_rx_sda_mid_change, input, 1: live flag from the receiving side; SDA changed while SCL was high.
REQ-011 Port i_rx_sda_final, input, 1: live SDA value from the receiving side at the end of the high phase.
REQ-012 Port i_rx_done, input, 1: the receiving side has finished its bit.
REQ-013 Port i_scl, input, 1: sampled bus SCL.
REQ-014 Port o_scl, output, 1: 0 means pull SCL low; 1 means release.
REQ-015 Port o_sda, output, 1: 0 means pull SDA low; 1 means release.
REQ-016 Port o_tx_done, output, 1: idle, ready for i_start_tx.
REQ-017 Port o_violation, output, 1: sticky SCL-contention flag.

Function
REQ-018 Timer operation:
- Loads F_REF_T_LOW on reset-request.
- Otherwise decrements by 1 on each i_f_ref rising edge (prev=0, now=1); saturates at 0.
- tc is timer==0.
REQ-019 All outputs decode from the state register and latched bits only; there is no combinational input-to-output path.
REQ-020 ST_IDLE outputs: o_scl=0, o_sda=sda_hold, o_tx_done=1, timer held in reset-request.
- On i_start_tx: latch init=i_tx_sda_init and rel=i_tx_release_sda, then go to ST_SCL0_SETUP.
REQ-021 drv means 1 if rel=1, otherwise the per-state SDA value.
REQ-022 ST_SCL0_SETUP: o_scl=0, o_sda=drv(init).
- On tc: go to ST_SCL0_RELEASE.
REQ-023 ST_SCL0_RELEASE: o_scl=1, o_sda=drv(init), timer held in reset-request.
- On i_scl=1: go to ST_SCL1_INIT. Clock stretching is unbounded.
REQ-024 ST_SCL1_INIT: o_scl=1, o_sda=drv(init).
- On tc and i_rx_sda_mid_change: go to ST_SCL1_MID and reload the timer.
- On tc and i_rx_done and not mid_change: go to ST_SCL0_END.
REQ-025 ST_SCL1_MID: o_scl=1, o_sda=drv(~init).
- On tc and i_rx_done: if i_rx_sda_final==init, go to ST_SCL1_FIN and reload the timer; otherwise go to ST_SCL0_END.
REQ-026 ST_SCL1_FIN: o_scl=1, o_sda=drv(init).
- On tc: go to ST_SCL0_END.
REQ-027 ST_SCL0_END: o_scl=0, o_sda=last driven value.
- Update sda_hold to that value.
- Go to ST_IDLE in exactly 1 cycle.
REQ-028 In ST_SCL1_INIT, ST_SCL1_MID or ST_SCL1_FIN, i_scl=0 sends the block to ST_VIOLATION. This check takes priority over all other transitions.
REQ-029 ST_VIOLATION: o_violation=1, o_scl=1, o_sda=1, o_tx_done=0. The only exit is reset.
REQ-030 i_start_tx outside ST_IDLE is ignored.
- Mid-change and done inputs are ignored until tc.
- If tc and i_rx_done coincide with mid_change in ST_SCL1_INIT, ST_SCL1_MID wins.
REQ-031 Unencoded state values go to ST_IDLE on the next cycle.

Reset
REQ-032 While i_rst=1, asynchronously:
- state=ST_IDLE, sda_hold=1, init=1, rel=1, prev f_ref=0, timer=F_REF_T_LOW.
- Outputs are therefore o_scl=0, o_sda=1, o_tx_done=1, o_violation=0.
REQ-033 Reset asserted mid-bit aborts immediately, with no completion of SCL or SDA sequencing.

Structure
REQ-034 Package i2c_passthru_pkg holds the state encodings (4-bit) and the default F_REF_T_LOW and WIDTH values.
REQ-035 Sub-module i2c_passthru_reftimer holds the f_ref edge detect and the saturating down-counter with load, shared with the receive side.

Verification (F_REF_T_LOW=4; i_f_ref period 4 clocks)
REQ-036 Data bit, init=0, no mid_change, i_rx_done at tc:
- o_sda=0 throughout.
- o_scl is low for ≥4 f_ref edges, then high for ≥4 edges.
- o_tx_done returns 1 cycle after ST_SCL0_END.
REQ-037 Start condition, init=1, mid_change=1, final=0:
- o_sda goes 1→0 while o_scl=1, at ≥4 edges after the SCL rise.
- Bit ends with o_scl=0, o_sda=0.
REQ-038 Stop-then-start, init=0, mid_change=1, final=0:
- o_sda goes 0→1→0 within the high phase, with each phase ≥4 edges.
REQ-039 Stretch: i_scl is held 0 for 50 cycles after o_scl=1.
- The block stays in ST_SCL0_RELEASE with no violation.
- The high-phase timer starts only after i_scl=1.
REQ-040 Contention: i_scl=0 during ST_SCL1_INIT.
- o_violation=1 next cycle and stays 1.
- i_rst pulse restores o_violation=0, o_tx_done=1.
REQ-041 Release mode: rel=1 with init=0.
- o_sda=1 for the entire bit.
- Asynchronous reset asserted mid ST_SCL1_MID gives o_scl=0, o_sda=1 without a clock edge.
